// File: rtl/alien_fire_scheduler_if.sv
// alien_fire_scheduler_if: signal bundle between swarm logic, scheduler and rocket slots
// master drives playing/tick/swarm position/column rows/flying flags and observes the launch;
// slave (the scheduler) observes those and drives fire/startX/startY/sel_col.
interface alien_fire_scheduler_if #(parameter int NUM_SLOTS = 4);
  logic                 playing;
  logic                 tick;
  logic [9:0]           swarmX;
  logic [8:0]           swarmY;
  logic [32:0]          col_row;
  logic [NUM_SLOTS-1:0] flying;
  logic [NUM_SLOTS-1:0] fire;
  logic [9:0]           startX;
  logic [8:0]           startY;
  logic [3:0]           sel_col;
  modport master (output playing, tick, swarmX, swarmY, col_row, flying,
                  input fire, startX, startY, sel_col);
  modport slave (input playing, tick, swarmX, swarmY, col_row, flying,
                 output fire, startX, startY, sel_col);
endinterface

// File: rtl/alien_fire_scheduler.sv
// alien_fire_scheduler: paces alien fire and hands each launch to the lowest idle rocket slot
// Ports: clk; reset (async, active-high); bus (slave): playing, tick, swarmX, swarmY,
//   col_row (3 bits/column bottom row), flying in; fire (one-hot pulse), startX/startY
//   (shared launch point), sel_col (column of last launch) out.
module alien_fire_scheduler #(
  parameter int          NUM_SLOTS = 4,
  parameter int          COOLDOWN  = 45,
  parameter int          COL_PITCH = 32,
  parameter int          COL_XOFF  = 14,
  parameter int          ROW_PITCH = 24,
  parameter int          ROW_YOFF  = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clk,
  input logic reset,
  alien_fire_scheduler_if.slave bus
);
  typedef enum logic [2:0] {COOL, PICK, SCAN, SLOT, FIRE, ACK} state_t;
  state_t               state, state_n;
  logic [7:0]           cnt, cnt_n;
  logic [15:0]          lfsr, lfsr_n;
  logic [3:0]           cand, cand_n, scan, scan_n, col, col_n;
  logic [NUM_SLOTS-1:0] oh, oh_n, idle;
  logic [9:0]           x, x_n;
  logic [8:0]           y, y_n;
  logic [2:0]           row;
  logic                 hit;
  // codes 6..7 are as empty as 0
  assign row  = bus.col_row[6'(cand) * 6'd3 +: 3];
  assign hit  = row != 3'd0 && row < 3'd6;
  // isolates the lowest clear bit of flying; zero when every slot is busy
  assign idle = ~bus.flying & (bus.flying + NUM_SLOTS'(1));
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    scan_n  = scan;
    oh_n    = oh;
    x_n     = x;
    y_n     = y;
    col_n   = col;
    lfsr_n  = bus.playing ? {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : lfsr;
    if (!bus.playing) begin
      state_n = COOL;
      cnt_n   = 8'(COOLDOWN);
    end else begin
      case (state)
        COOL: if (bus.tick) begin
          cnt_n   = cnt - 8'd1;
          state_n = cnt == 8'd1 ? PICK : COOL;
        end
        PICK: begin
          cand_n  = lfsr[3:0] > 4'd10 ? lfsr[3:0] - 4'd11 : lfsr[3:0];
          scan_n  = '0;
          state_n = SCAN;
        end
        SCAN: if (hit) state_n = SLOT;
        else if (scan == 4'd10) begin
          cnt_n   = 8'(COOLDOWN);
          state_n = COOL;
        end else begin
          cand_n = cand == 4'd10 ? 4'd0 : cand + 4'd1;
          scan_n = scan + 4'd1;
        end
        SLOT: if (|idle) begin
          oh_n    = idle;
          x_n     = bus.swarmX + 10'(cand) * 10'(COL_PITCH) + 10'(COL_XOFF);
          y_n     = bus.swarmY + 9'(row) * 9'(ROW_PITCH) + 9'(ROW_YOFF);
          col_n   = cand;
          state_n = FIRE;
        end
        FIRE: state_n = ACK;
        ACK: begin
          cnt_n   = 8'(COOLDOWN);
          state_n = COOL;
        end
        default: state_n = COOL;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= COOL;
      cnt   <= 8'(COOLDOWN);
      lfsr  <= LFSR_SEED;
      cand  <= '0;
      scan  <= '0;
      oh    <= '0;
      x     <= '0;
      y     <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lfsr  <= lfsr_n;
      cand  <= cand_n;
      scan  <= scan_n;
      oh    <= oh_n;
      x     <= x_n;
      y     <= y_n;
      col   <= col_n;
    end
  // decoded from state so an async reset cuts the pulse at once
  assign bus.fire    = state == FIRE ? oh : '0;
  assign bus.startX  = x;
  assign bus.startY  = y;
  assign bus.sel_col = col;
endmodule

// File: doc/alien_fire_scheduler.md
# alien_fire_scheduler

Schedules enemy fire for the alien swarm and shares a fixed pool of alien rocket instances between the 11 swarm columns. On each cooldown expiry it selects a pseudo-random non-empty column and computes the launch point under that column's lowest living alien. It then issues a one-cycle fire pulse to the lowest-indexed idle rocket slot. It sits between the swarm/alien-state logic and the array of rocket datapath instances, driving their fire/startX/startY inputs and monitoring their flying outputs.

## Interface
- NUM_SLOTS, 4, number of alien rocket instances managed (1..8)
- COOLDOWN, 45, frame ticks between successive fire attempts (1..255)
- COL_PITCH, 32, horizontal pixel spacing of swarm columns
- COL_XOFF, 14, x offset from column origin to rocket launch x
- ROW_PITCH, 24, vertical pixel spacing of swarm rows
- ROW_YOFF, 20, y offset from row origin to rocket launch y
- LFSR_SEED, 16'hACE1, nonzero reset value of 16-bit LFSR
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- playing  input  1  game running; low forces idle
- tick  input  1  one-cycle frame strobe
- swarmX  input  10  swarm origin x
- swarmY  input  9  swarm origin y
- col_row  input  33  3 bits per column (col c at [3c+2:3c]): 0 = column empty, 1..5 = bottom living row, 6..7 treated as empty
- flying  input  NUM_SLOTS  per-slot rocket flying flags
- fire  output  NUM_SLOTS  one-hot one-cycle launch pulse
- startX  output  10  launch x, shared by all slots
- startY  output  9  launch y, shared by all slots
- sel_col  output  4  column of last launch (debug/sound)

## Operation
- Reset values: fire=0, startX=0, startY=0, sel_col=0, state=COOL, cooldown counter=COOLDOWN, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk while playing; never zero.
- States:
  - COOL: decrement counter on each tick; at tick with counter==1, go to PICK.
  - PICK: candidate = LFSR[3:0] mod 11 (values 11..15 map to 0..4); load scan counter=0; go to SCAN.
  - SCAN: one column checked per cycle. If candidate column is non-empty, go to SLOT. Otherwise candidate = (candidate+1) wrapping 10→0, and scan counter++. After 11 empty checks, reload counter and go to COOL, with no fire.
  - SLOT: if any flying bit is 0, latch startX = swarmX + cand*COL_PITCH + COL_XOFF (mod 1024) and startY = swarmY + row*ROW_PITCH + ROW_YOFF (mod 512), and set sel_col=cand, then go to FIRE. If all slots are flying, stay in SLOT (the attempt is held, not dropped).
  - FIRE: fire = one-hot of lowest-index idle slot (chosen in SLOT), for exactly one cycle; go to ACK.
  - ACK: one cycle for flying to rise; reload counter=COOLDOWN; go to COOL.
- playing low (synchronous, checked before all else): fire=0, state=COOL, counter=COOLDOWN; startX/startY/sel_col hold; LFSR holds.
- col_row, swarmX, swarmY are sampled in SCAN/SLOT only. Changes after SLOT do not affect the latched launch point.

## Timing
- Minimum tick-to-fire latency: tick ending COOL → PICK (1) → SCAN hit (1) → SLOT (1) → fire asserted on the 4th cycle after the tick edge.
- Worst-case scan adds 10 cycles.
- startX/startY are valid from the cycle fire rises and are held until the next SLOT latch.
- fire is never asserted to a slot whose flying bit was 1 in the SLOT cycle. fire is never multi-hot.
- Reset mid-operation: immediate return to reset values; an in-progress fire pulse is cut.
- tick arriving in non-COOL states is ignored. The cooldown restarts only from ACK or a failed scan.

## Test plan
- Reset, playing=1, COOLDOWN=3, all col_row=1, swarm=(0,0), LFSR forced candidate 2 → after 3 ticks, fire=4'b0001, startX=78, startY=44, sel_col=2.
- Only column 10 non-empty (row 5), candidate 0 → 10 scan misses, then fire with startX=334 and startY=140.
- All columns empty → no fire ever, and the FSM returns to COOL after 11 SCAN cycles each attempt.
- flying=4'b1011 → fire=4'b0100. flying=4'b1111 → SLOT holds; dropping flying[3] yields fire=4'b1000.
- swarmX=1020, cand=0 → startX wraps to 10.
- playing dropped in SLOT/FIRE, or reset asserted mid-FIRE → fire=0 next edge (async for reset), state COOL, counter=COOLDOWN.
